// File: rtl/fifo_read_sequencer.sv
// fifo_read_sequencer
//   Read-side controller for the shared capture FIFO (cwusb_clk domain).
//   Turns an N-word burst request into paced FIFO read enables, absorbs the
//   FIFO's one-cycle read latency with a 2-entry in-order buffer, pads the
//   burst with PAD_WORD when capture data stops arriving, and runs FIFO
//   flushes only between bursts.
//
// Ports
//   cwusb_clk, reset_i          clock, async active-high reset
//   I_burst_start, I_burst_len  burst request (sampled in IDLE only)
//   I_abort                     kill current burst / flush
//   I_flush_req                 flush request pulse (deferred while busy)
//   I_fifo_empty, I_fifo_data   FIFO status / read data (1-cycle latency)
//   O_fifo_rd_en, O_fifo_flush  FIFO controls
//   O_data, O_data_valid,
//   I_data_ready                output valid/ready handshake
//   O_busy, O_words_left,
//   O_burst_done, O_underrun    status
module fifo_read_sequencer #(
    parameter int          LEN_W    = 16,
    parameter int          TIMEOUT  = 255,
    parameter logic [17:0] PAD_WORD = 18'h3FFFF
) (
    input  logic             cwusb_clk,
    input  logic             reset_i,
    input  logic             I_burst_start,
    input  logic [LEN_W-1:0] I_burst_len,
    input  logic             I_abort,
    input  logic             I_flush_req,
    input  logic             I_fifo_empty,
    input  logic [17:0]      I_fifo_data,
    output logic             O_fifo_rd_en,
    output logic             O_fifo_flush,
    output logic [17:0]      O_data,
    output logic             O_data_valid,
    input  logic             I_data_ready,
    output logic             O_busy,
    output logic [LEN_W-1:0] O_words_left,
    output logic             O_burst_done,
    output logic             O_underrun
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, PAD, FLUSH} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] words_left, words_n;
    logic [LEN_W-1:0] issued, issued_n;
    logic [17:0]      mem0, mem1, mem0_n, mem1_n;
    logic [1:0]       occ, occ_n;
    logic             infl, infl_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic             flush_pend, pend_n;
    logic             seen_empty, seen_n;
    logic             done_r, done_n;
    logic             under_r, under_n;

    logic             head_vld, pop, rd_en, pad_push, in_vld, go_flush;
    logic [2:0]       fill;
    logic [17:0]      in_word;

    always_comb begin
        // The word landing on I_fifo_data this cycle counts as a buffer entry
        // so a read at t is presentable at t+1 (bypass when buffer is empty).
        head_vld = (occ != 2'd0) || infl;
        pop      = head_vld && I_data_ready;
        fill     = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        rd_en    = (state == READ) && !I_abort && (issued != '0) &&
                   !I_fifo_empty && (fill < 3'd2);
        pad_push = (state == PAD) && !I_abort && (issued != '0) && (fill < 3'd2);
        in_vld   = infl || pad_push;
        in_word  = infl ? I_fifo_data : PAD_WORD;
        go_flush = flush_pend || I_flush_req;

        state_n  = state;
        words_n  = words_left - {{(LEN_W-1){1'b0}}, pop};
        issued_n = issued - {{(LEN_W-1){1'b0}}, (rd_en || pad_push)};
        mem0_n   = mem0;
        mem1_n   = mem1;
        occ_n    = occ;
        infl_n   = rd_en;
        tcnt_n   = tcnt;
        pend_n   = flush_pend;
        seen_n   = seen_empty;
        done_n   = 1'b0;
        under_n  = under_r;

        // In-order buffer: pop shifts, the incoming word appends at the tail.
        // A pop with occ==0 consumes the landing word directly.
        if (pop && occ != 2'd0) begin
            mem0_n = mem1;
            if (in_vld) begin
                if (occ == 2'd1) mem0_n = in_word;
                else             mem1_n = in_word;
            end
            occ_n = occ - 2'd1 + {1'b0, in_vld};
        end else if (!pop && in_vld) begin
            if (occ == 2'd0) mem0_n = in_word;
            else             mem1_n = in_word;
            occ_n = occ + 2'd1;
        end

        case (state)
            IDLE: begin
                tcnt_n = '0;
                seen_n = 1'b0;
                if (go_flush) begin
                    state_n = FLUSH;
                    pend_n  = 1'b0;
                end else if (I_burst_start) begin
                    under_n = 1'b0;
                    if (I_burst_len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = READ;
                        words_n  = I_burst_len;
                        issued_n = I_burst_len;
                    end
                end
            end
            READ, PAD: begin
                if (I_flush_req) pend_n = 1'b1;
                if (state == READ) begin
                    if (rd_en) begin
                        tcnt_n = '0;
                    end else if (issued != '0 && I_fifo_empty && !infl) begin
                        tcnt_n = tcnt + TW'(1);
                        if (tcnt == TO_LAST) begin
                            state_n = PAD;
                            under_n = 1'b1;
                            tcnt_n  = '0;
                        end
                    end
                end
                if (pop && words_left == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                    done_n  = 1'b1;
                    state_n = go_flush ? FLUSH : IDLE;
                    pend_n  = 1'b0;
                    tcnt_n  = '0;
                end
            end
            FLUSH: begin
                // Two consecutive empty samples cover the empty-flag latency.
                seen_n = I_fifo_empty;
                if (I_fifo_empty && seen_empty) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (I_abort && state != IDLE) begin
            occ_n    = 2'd0;
            infl_n   = 1'b0;
            words_n  = '0;
            issued_n = '0;
            tcnt_n   = '0;
            seen_n   = 1'b0;
            done_n   = 1'b0;
            state_n  = (state != FLUSH && go_flush) ? FLUSH : IDLE;
            pend_n   = 1'b0;
        end
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            words_left <= '0;
            issued     <= '0;
            mem0       <= '0;
            mem1       <= '0;
            occ        <= 2'd0;
            infl       <= 1'b0;
            tcnt       <= '0;
            flush_pend <= 1'b0;
            seen_empty <= 1'b0;
            done_r     <= 1'b0;
            under_r    <= 1'b0;
        end else begin
            state      <= state_n;
            words_left <= words_n;
            issued     <= issued_n;
            mem0       <= mem0_n;
            mem1       <= mem1_n;
            occ        <= occ_n;
            infl       <= infl_n;
            tcnt       <= tcnt_n;
            flush_pend <= pend_n;
            seen_empty <= seen_n;
            done_r     <= done_n;
            under_r    <= under_n;
        end
    end

    assign O_fifo_rd_en = rd_en;
    assign O_fifo_flush = (state == FLUSH);
    assign O_data       = (occ == 2'd0 && infl) ? I_fifo_data : mem0;
    assign O_data_valid = head_vld;
    assign O_busy       = (state != IDLE);
    assign O_words_left = words_left;
    assign O_burst_done = done_r;
    assign O_underrun   = under_r;

endmodule

// File: tb/tb_fifo_read_sequencer.sv
// Directed bench for fifo_read_sequencer with a small behavioural FIFO model.
module tb_fifo_read_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_burst_start = 1'b0;
    logic [15:0] I_burst_len = '0;
    logic        I_abort = 1'b0;
    logic        I_flush_req = 1'b0;
    logic        I_fifo_empty;
    logic [17:0] I_fifo_data = '0;
    logic        O_fifo_rd_en, O_fifo_flush, O_data_valid;
    logic [17:0] O_data;
    logic        I_data_ready = 1'b0;
    logic        O_busy, O_burst_done, O_underrun;
    logic [15:0] O_words_left;

    int nvec = 0;
    int nerr = 0;
    int uf_cnt = 0;

    logic [17:0] fmem [0:63];
    logic [5:0]  wp = '0;
    logic [5:0]  rp = '0;

    always #5 clk = ~clk;

    fifo_read_sequencer #(.LEN_W(16), .TIMEOUT(4), .PAD_WORD(18'h3FFFF)) dut (
        .cwusb_clk(clk), .reset_i(rst),
        .I_burst_start(I_burst_start), .I_burst_len(I_burst_len),
        .I_abort(I_abort), .I_flush_req(I_flush_req),
        .I_fifo_empty(I_fifo_empty), .I_fifo_data(I_fifo_data),
        .O_fifo_rd_en(O_fifo_rd_en), .O_fifo_flush(O_fifo_flush),
        .O_data(O_data), .O_data_valid(O_data_valid), .I_data_ready(I_data_ready),
        .O_busy(O_busy), .O_words_left(O_words_left),
        .O_burst_done(O_burst_done), .O_underrun(O_underrun)
    );

    // FIFO model: registered read data, flush empties it on the next edge.
    assign I_fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (O_fifo_flush) begin
            rp <= wp;
        end else if (O_fifo_rd_en) begin
            if (wp == rp) uf_cnt <= uf_cnt + 1;
            I_fifo_data <= fmem[rp];
            rp <= rp + 6'd1;
        end
    end

    task automatic push_words(input logic [17:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wp] = base + 18'(i);
            wp = wp + 6'd1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        nvec++; if (O_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", O_busy); end
        nvec++; if (O_words_left !== 16'd0) begin nerr++; $display("FAIL reset_words_left: got %0d want 0", O_words_left); end
        nvec++; if ({O_fifo_rd_en, O_fifo_flush, O_data_valid, O_burst_done, O_underrun} !== 5'b0)
            begin nerr++; $display("FAIL reset_flags: got %b want 00000", {O_fifo_rd_en, O_fifo_flush, O_data_valid, O_burst_done, O_underrun}); end
        nvec++; if (O_data !== 18'd0) begin nerr++; $display("FAIL reset_data: got %h want 0", O_data); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic;
        int npop = 0;
        push_words(18'h100, 8);
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd8; I_data_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            I_burst_start = (c == 3);           // start while busy: must be ignored
            I_burst_len   = (c == 3) ? 16'd2 : 16'd8;
            #1;
            nvec++; if (O_fifo_rd_en !== (c <= 8)) begin nerr++; $display("FAIL basic_rd_en c%0d: got %b want %b", c, O_fifo_rd_en, (c <= 8)); end
            if (O_data_valid && I_data_ready) begin
                nvec++; if (O_data !== 18'h100 + 18'(npop)) begin nerr++; $display("FAIL basic_data %0d: got %h want %h", npop, O_data, 18'h100 + 18'(npop)); end
                npop++;
            end
            nvec++; if (O_burst_done !== (c == 10)) begin nerr++; $display("FAIL basic_done c%0d: got %b want %b", c, O_burst_done, (c == 10)); end
            if (c == 1) begin nvec++; if (O_busy !== 1'b1 || O_data_valid !== 1'b0) begin nerr++; $display("FAIL basic_first busy/valid: got %b%b want 10", O_busy, O_data_valid); end end
            if (c == 2) begin nvec++; if (O_data_valid !== 1'b1) begin nerr++; $display("FAIL basic_latency: got %b want 1", O_data_valid); end end
            if (c == 4) begin nvec++; if (O_words_left !== 16'd6) begin nerr++; $display("FAIL basic_ignore_start: got %0d want 6", O_words_left); end end
        end
        nvec++; if (npop != 8) begin nerr++; $display("FAIL basic_count: got %0d want 8", npop); end
        nvec++; if (O_underrun !== 1'b0 || O_busy !== 1'b0) begin nerr++; $display("FAIL basic_end underrun/busy: got %b%b want 00", O_underrun, O_busy); end
    endtask

    task automatic test_backpressure;
        int npop = 0, nrd = 0, ndone = 0;
        push_words(18'h200, 8);
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd8; I_data_ready = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            I_burst_start = 1'b0;
            I_data_ready  = (c % 2 == 1);
            #1;
            nvec++; if (O_words_left !== 16'(8 - npop)) begin nerr++; $display("FAIL bp_words_left c%0d: got %0d want %0d", c, O_words_left, 8 - npop); end
            if (O_fifo_rd_en) nrd++;
            if (O_data_valid && I_data_ready) begin
                nvec++; if (O_data !== 18'h200 + 18'(npop)) begin nerr++; $display("FAIL bp_data %0d: got %h want %h", npop, O_data, 18'h200 + 18'(npop)); end
                npop++;
            end
            nvec++; if (nrd - npop > 2) begin nerr++; $display("FAIL bp_occupancy c%0d: got %0d want <=2", c, nrd - npop); end
            if (O_burst_done) ndone++;
        end
        nvec++; if (npop != 8 || nrd != 8) begin nerr++; $display("FAIL bp_totals: got pops %0d reads %0d want 8 8", npop, nrd); end
        nvec++; if (ndone != 1) begin nerr++; $display("FAIL bp_done: got %0d want 1", ndone); end
    endtask

    task automatic test_starve;
        int npop = 0, nrd = 0;
        logic [17:0] exp [0:5];
        exp[0] = 18'h300; exp[1] = 18'h301; exp[2] = 18'h302;
        exp[3] = 18'h3FFFF; exp[4] = 18'h3FFFF; exp[5] = 18'h3FFFF;
        push_words(18'h300, 3);
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd6; I_data_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); I_burst_start = 1'b0; #1;
            if (O_fifo_rd_en) nrd++;
            if (O_data_valid && I_data_ready) begin
                nvec++; if (npop > 5 || O_data !== exp[npop > 5 ? 5 : npop]) begin nerr++; $display("FAIL starve_data %0d: got %h want %h", npop, O_data, exp[npop > 5 ? 5 : npop]); end
                npop++;
            end
            nvec++; if (O_burst_done !== (c == 13)) begin nerr++; $display("FAIL starve_done c%0d: got %b want %b", c, O_burst_done, (c == 13)); end
            if (c == 8) begin nvec++; if (O_underrun !== 1'b0) begin nerr++; $display("FAIL starve_early_underrun: got %b want 0", O_underrun); end end
            if (c == 9) begin nvec++; if (O_underrun !== 1'b1 || O_data_valid !== 1'b0) begin nerr++; $display("FAIL starve_pad_entry underrun/valid: got %b%b want 10", O_underrun, O_data_valid); end end
        end
        nvec++; if (nrd != 3 || npop != 6) begin nerr++; $display("FAIL starve_totals: got reads %0d pops %0d want 3 6", nrd, npop); end
        nvec++; if (O_underrun !== 1'b1 || O_busy !== 1'b0) begin nerr++; $display("FAIL starve_end underrun/busy: got %b%b want 10", O_underrun, O_busy); end
    endtask

    task automatic test_flush_mid;
        int npop = 0;
        push_words(18'h400, 6);
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd4; I_data_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); I_burst_start = 1'b0; I_flush_req = (c == 2); #1;
            nvec++; if (O_fifo_flush !== (c >= 6 && c <= 8)) begin nerr++; $display("FAIL flush_mid_flush c%0d: got %b want %b", c, O_fifo_flush, (c >= 6 && c <= 8)); end
            nvec++; if (O_fifo_rd_en !== (c <= 4)) begin nerr++; $display("FAIL flush_mid_rd_en c%0d: got %b want %b", c, O_fifo_rd_en, (c <= 4)); end
            if (O_data_valid && I_data_ready) begin
                nvec++; if (O_data !== 18'h400 + 18'(npop)) begin nerr++; $display("FAIL flush_mid_data %0d: got %h want %h", npop, O_data, 18'h400 + 18'(npop)); end
                npop++;
            end
            nvec++; if (O_burst_done !== (c == 6)) begin nerr++; $display("FAIL flush_mid_done c%0d: got %b want %b", c, O_burst_done, (c == 6)); end
            nvec++; if (O_busy !== (c <= 8)) begin nerr++; $display("FAIL flush_mid_busy c%0d: got %b want %b", c, O_busy, (c <= 8)); end
        end
        nvec++; if (npop != 4 || I_fifo_empty !== 1'b1) begin nerr++; $display("FAIL flush_mid_end: got pops %0d empty %b want 4 1", npop, I_fifo_empty); end
    endtask

    task automatic test_abort;
        push_words(18'h500, 6);
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd5; I_data_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); I_burst_start = 1'b0;
            if (c == 4) begin I_abort = 1'b1; I_data_ready = 1'b0; end
            #1;
            nvec++; if (O_fifo_rd_en !== (c <= 3)) begin nerr++; $display("FAIL abort_rd_en c%0d: got %b want %b", c, O_fifo_rd_en, (c <= 3)); end
            if (c == 2 || c == 3) begin
                nvec++; if (O_data !== 18'h500 + 18'(c - 2)) begin nerr++; $display("FAIL abort_data c%0d: got %h want %h", c, O_data, 18'h500 + 18'(c - 2)); end
            end
        end
        @(negedge clk); I_abort = 1'b0; #1;
        nvec++; if ({O_busy, O_data_valid, O_burst_done} !== 3'b000) begin nerr++; $display("FAIL abort_after busy/valid/done: got %b want 000", {O_busy, O_data_valid, O_burst_done}); end
        nvec++; if (O_words_left !== 16'd0) begin nerr++; $display("FAIL abort_words_left: got %0d want 0", O_words_left); end
        I_burst_start = 1'b1; I_burst_len = 16'd1; I_data_ready = 1'b1;
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk); I_burst_start = 1'b0; #1;
            nvec++; if (O_data_valid !== (c == 7)) begin nerr++; $display("FAIL abort_next_valid c%0d: got %b want %b", c, O_data_valid, (c == 7)); end
            if (c == 7) begin nvec++; if (O_data !== 18'h503) begin nerr++; $display("FAIL abort_next_data: got %h want 503", O_data); end end
            nvec++; if (O_burst_done !== (c == 8)) begin nerr++; $display("FAIL abort_next_done c%0d: got %b want %b", c, O_burst_done, (c == 8)); end
        end
    endtask

    task automatic test_idle_flush;
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd3; I_flush_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); I_burst_start = 1'b0; I_flush_req = 1'b0; #1;
            nvec++; if (O_fifo_flush !== (c <= 3)) begin nerr++; $display("FAIL idle_flush c%0d: got %b want %b", c, O_fifo_flush, (c <= 3)); end
            nvec++; if (O_words_left !== 16'd0 || O_fifo_rd_en !== 1'b0 || O_burst_done !== 1'b0)
                begin nerr++; $display("FAIL idle_flush_start_dropped c%0d: got wl %0d rd %b done %b want 0 0 0", c, O_words_left, O_fifo_rd_en, O_burst_done); end
        end
        nvec++; if (O_busy !== 1'b0 || I_fifo_empty !== 1'b1) begin nerr++; $display("FAIL idle_flush_end busy/empty: got %b%b want 01", O_busy, I_fifo_empty); end
    endtask

    task automatic test_async_reset;
        push_words(18'h600, 4);
        @(negedge clk); I_burst_start = 1'b1; I_burst_len = 16'd4; I_data_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin @(negedge clk); I_burst_start = 1'b0; end
        #1;
        nvec++; if (O_data_valid !== 1'b1 || O_words_left !== 16'd4) begin nerr++; $display("FAIL areset_pre valid/wl: got %b %0d want 1 4", O_data_valid, O_words_left); end
        #2 rst = 1'b1;
        #1;
        nvec++; if ({O_fifo_rd_en, O_fifo_flush, O_data_valid, O_busy, O_burst_done, O_underrun} !== 6'b0)
            begin nerr++; $display("FAIL areset_flags: got %b want 000000", {O_fifo_rd_en, O_fifo_flush, O_data_valid, O_busy, O_burst_done, O_underrun}); end
        nvec++; if (O_data !== 18'd0 || O_words_left !== 16'd0) begin nerr++; $display("FAIL areset_data/wl: got %h %0d want 0 0", O_data, O_words_left); end
        @(negedge clk); rst = 1'b0; I_burst_start = 1'b1; I_burst_len = 16'd0;
        @(negedge clk); I_burst_start = 1'b0; #1;
        nvec++; if (O_burst_done !== 1'b1 || O_busy !== 1'b0) begin nerr++; $display("FAIL zero_len done/busy: got %b%b want 10", O_burst_done, O_busy); end
        @(negedge clk); #1;
        nvec++; if (O_burst_done !== 1'b0 || O_fifo_rd_en !== 1'b0) begin nerr++; $display("FAIL zero_len_after done/rd: got %b%b want 00", O_burst_done, O_fifo_rd_en); end
        nvec++; if (uf_cnt != 0) begin nerr++; $display("FAIL fifo_underflow: got %0d want 0", uf_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_starve();
        test_flush_mid();
        test_abort();
        test_idle_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
